// File: rtl/dm_bus_pkg.sv
// -----------------------------------------------------------------------------
// dm_bus_pkg
// Shared definitions for the data-memory bus bridge: FSM state encoding,
// the all-lanes byte-enable constant used for reads, and the default word
// returned to the load path when a read is aborted.
// -----------------------------------------------------------------------------
package dm_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [3:0]  BE_ALL           = 4'b1111;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/dm_bus_bridge_if.sv
// -----------------------------------------------------------------------------
// dm_bus_bridge_if
// Data-memory bus between the bridge (master) and the memory (slave).
//   BusReq  : transaction request, held high for the whole transaction
//   BusWe   : 1 = write transaction
//   BusAddr : 30-bit word address
//   BusBE   : byte enables (all ones for reads)
//   BusWD   : write data
//   BusAck  : transaction complete, BusRD valid in the same cycle
//   BusRD   : read data
// -----------------------------------------------------------------------------
interface dm_bus_bridge_if;

  logic        BusReq;
  logic        BusWe;
  logic [29:0] BusAddr;
  logic [3:0]  BusBE;
  logic [31:0] BusWD;
  logic        BusAck;
  logic [31:0] BusRD;

  modport master (
    output BusReq, BusWe, BusAddr, BusBE, BusWD,
    input  BusAck, BusRD
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusBE, BusWD,
    output BusAck, BusRD
  );

endinterface

// File: rtl/dm_timeout_cnt.sv
// -----------------------------------------------------------------------------
// dm_timeout_cnt
// Counts BUSY cycles of a bus transaction and flags the last allowed one.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   clr     : synchronous clear (bridge idle, next transaction starts at 0)
//   en      : count one more waiting cycle
//   expired : current cycle is the TIMEOUT-th waiting cycle
// -----------------------------------------------------------------------------
module dm_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST so a held enable can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dm_bus_bridge.sv
// -----------------------------------------------------------------------------
// dm_bus_bridge
// Memory-stage bridge: turns a store/load request from the pipeline into one
// req/ack transaction on the data-memory bus, stalls the pipeline until it
// completes, and returns the raw read word. Hung transactions are aborted
// after TIMEOUT waiting cycles.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   Addr     : byte address (only [31:2] used)
//   WD, BE   : lane-aligned store word and byte enables
//   DMWe     : store request (wins over MemRead)
//   MemRead  : load request
//   Stall    : freeze pipeline up to MEM (combinational)
//   RD       : raw read word, registered, held until the next read completes
//   BusErr   : one-cycle pulse when a transaction times out
//   bus      : data-memory bus, master side
// -----------------------------------------------------------------------------
module dm_bus_bridge
  import dm_bus_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            Addr,
  input  logic [31:0]            WD,
  input  logic [3:0]             BE,
  input  logic                   DMWe,
  input  logic                   MemRead,
  output logic                   Stall,
  output logic [31:0]            RD,
  output logic                   BusErr,
  dm_bus_bridge_if.master        bus
);

  state_e      state_q,    state_d;
  logic        bus_req_q,  bus_req_d;
  logic        bus_we_q,   bus_we_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q,   bus_be_d;
  logic [31:0] bus_wd_q,   bus_wd_d;
  logic [31:0] rd_q,       rd_d;
  logic        bus_err_q,  bus_err_d;

  logic acc;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_expired;

  // Byte offset is irrelevant on a word-wide bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr[1:0];

  assign acc = DMWe | MemRead;

  // Gated by reset so nothing is requested of the pipeline while the bridge
  // is held in reset, even if the CPU still drives an access.
  assign Stall = reset & (((state_q == IDLE) & acc) | (state_q == BUSY));

  dm_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d    = state_q;
    bus_req_d  = bus_req_q;
    bus_we_d   = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_be_d   = bus_be_q;
    bus_wd_d   = bus_wd_q;
    rd_d       = rd_q;
    bus_err_d  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Counter is kept at zero while idle, so every transaction starts
        // its timeout window fresh.
        cnt_clr = 1'b1;
        if (acc) begin
          bus_addr_d = Addr[31:2];
          bus_we_d   = DMWe;
          bus_be_d   = DMWe ? BE : BE_ALL;
          bus_wd_d   = DMWe ? WD : '0;
          bus_req_d  = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // Ack is tested first so an ack in the timeout cycle still completes
        // normally without an error pulse.
        if (bus.BusAck) begin
          if (!bus_we_q) begin
            rd_d = bus.BusRD;
          end
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_expired) begin
          bus_err_d = 1'b1;
          if (!bus_we_q) begin
            rd_d = ERR_DATA;
          end
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        // One unstalled cycle lets the instruction leave MEM; a new access
        // seen here is picked up in the following IDLE cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_be_q   <= '0;
      bus_wd_q   <= '0;
      rd_q       <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bus_req_q  <= bus_req_d;
      bus_we_q   <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_be_q   <= bus_be_d;
      bus_wd_q   <= bus_wd_d;
      rd_q       <= rd_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign bus.BusReq  = bus_req_q;
  assign bus.BusWe   = bus_we_q;
  assign bus.BusAddr = bus_addr_q;
  assign bus.BusBE   = bus_be_q;
  assign bus.BusWD   = bus_wd_q;
  assign RD          = rd_q;
  assign BusErr      = bus_err_q;

endmodule

// File: tb/tb_dm_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dm_bus_bridge
// Scoreboard bench for dm_bus_bridge. The driver issues accesses and pushes
// the expected bus request and completion (stall length, RD, BusErr) into a
// queue; a memory responder acks after a chosen number of BUSY cycles; a
// monitor compares what the bridge presents against the queue.
// -----------------------------------------------------------------------------
module tb_dm_bus_bridge;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          stall;
  } exp_t;

  typedef struct {
    int          delay;   // ack on this BUSY cycle (1-based), 0 = never
    logic [31:0] data;
  } cfg_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [3:0]  BE;
  logic        DMWe;
  logic        MemRead;
  logic        Stall;
  logic [31:0] RD;
  logic        BusErr;

  dm_bus_bridge_if bus ();

  dm_bus_bridge #(
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (ERR_WORD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WD      (WD),
    .BE      (BE),
    .DMWe    (DMWe),
    .MemRead (MemRead),
    .Stall   (Stall),
    .RD      (RD),
    .BusErr  (BusErr),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  cfg_t        cfg_q[$];
  int          n_vec   = 0;
  int          n_err   = 0;
  bit          mon_en  = 1'b0;
  bit          stray   = 1'b0;
  bit          abort   = 1'b0;
  logic [31:0] model_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int   k = 0;
    cfg_t c;
    c.delay = 0;
    c.data  = '0;
    bus.BusAck = 1'b0;
    bus.BusRD  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.BusAck = 1'b0;
      bus.BusRD  = $urandom;
      if (bus.BusReq) begin
        k++;
        if (k == 1) begin
          if (cfg_q.size() > 0) c = cfg_q.pop_front();
          else begin c.delay = 0; c.data = '0; end
        end
        if (c.delay == k) begin
          bus.BusAck = 1'b1;
          bus.BusRD  = c.data;
        end
      end else begin
        k = 0;
        if (stray) begin
          bus.BusAck = 1'b1;
          stray      = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int   stall_cnt  = 0;
    bit   prev_stall = 1'b0;
    bit   prev_req   = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_cnt  = 0;
        prev_stall = 1'b0;
        prev_req   = 1'b0;
      end else begin
        if (bus.BusReq && !prev_req) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_req", 32'(bus.BusReq), 32'd0);
          end else begin
            e = exp_q[0];
            chk("bus_addr", 32'(bus.BusAddr), 32'(e.addr));
            chk("bus_we",   32'(bus.BusWe),   32'(e.we));
            chk("bus_be",   32'(bus.BusBE),   32'(e.be));
            chk("bus_wd",   bus.BusWD,        e.wd);
          end
        end
        if (Stall) begin
          // Every stalled cycle after the first is BUSY and must hold the request.
          if (stall_cnt > 0) chk("req_held", 32'(bus.BusReq), 32'd1);
          chk("err_quiet", 32'(BusErr), 32'd0);
          stall_cnt++;
        end else if (prev_stall) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(stall_cnt), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("stall_len",   32'(stall_cnt),     32'(e.stall));
            chk("rd_done",     RD,                 e.rd);
            chk("bus_err",     32'(BusErr),        32'(e.err));
            chk("req_done",    32'(bus.BusReq),    32'd0);
          end
          stall_cnt = 0;
        end else begin
          chk("err_quiet", 32'(BusErr), 32'd0);
        end
        prev_stall = Stall;
        prev_req   = bus.BusReq;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle_inputs();
    DMWe    = 1'b0;
    MemRead = 1'b0;
    Addr    = $urandom;
    WD      = $urandom;
    BE      = 4'($urandom);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge with the bridge in IDLE or DONE; returns
  // in the DONE cycle of this access with the inputs still driven.
  task automatic do_access(input bit we, input bit re, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be,
                           input int delay, input logic [31:0] data);
    exp_t e;
    cfg_t c;
    int   busy;
    int   n;
    if (abort) return;
    busy    = (delay == 0) ? TIMEOUT : delay;
    e.addr  = addr[31:2];
    e.we    = we;
    e.be    = we ? be : 4'hF;
    e.wd    = we ? wd : 32'd0;
    e.err   = (delay == 0);
    e.stall = 1 + busy;
    if (!we) model_rd = (delay == 0) ? ERR_WORD : data;
    e.rd    = model_rd;
    c.delay = delay;
    c.data  = data;
    cfg_q.push_back(c);
    exp_q.push_back(e);
    Addr    = addr;
    WD      = wd;
    BE      = be;
    DMWe    = we;
    MemRead = re;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (Stall && n < TIMEOUT + 6);
    if (Stall) begin
      chk("stall_bound", 32'(Stall), 32'd0);
      abort = 1'b1;
    end
  endtask

  initial begin
    bit          we, re, b2b;
    int          delay;
    logic [31:0] a;
    reset = 1'b0;
    idle_inputs();

    // Reset state.
    #3;
    chk("rst_req",   32'(bus.BusReq),  32'd0);
    chk("rst_stall", 32'(Stall),       32'd0);
    chk("rst_rd",    RD,               32'd0);
    chk("rst_err",   32'(BusErr),      32'd0);
    chk("rst_addr",  32'(bus.BusAddr), 32'd0);
    chk("rst_be",    32'(bus.BusBE),   32'd0);
    chk("rst_wd",    bus.BusWD,        32'd0);
    chk("rst_we",    32'(bus.BusWe),   32'd0);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);

    // Reset asserted mid-transaction abandons it at once.
    begin
      cfg_t c;
      c.delay = 0;
      c.data  = '0;
      cfg_q.push_back(c);
      Addr    = 32'h0000_0040;
      MemRead = 1'b1;
      wait_cycles(3);
      chk("pre_rst_req", 32'(bus.BusReq), 32'd1);
      #2;
      reset = 1'b0;
      MemRead = 1'b0;
      #1;
      chk("mid_rst_req",   32'(bus.BusReq), 32'd0);
      chk("mid_rst_stall", 32'(Stall),      32'd0);
      wait_cycles(2);
      reset = 1'b1;
      wait_cycles(2);
      chk("post_rst_rd",    RD,               32'd0);
      chk("post_rst_stall", 32'(Stall),       32'd0);
      chk("post_rst_req",   32'(bus.BusReq),  32'd0);
      cfg_q.delete();
    end
    model_rd = '0;
    mon_en   = 1'b1;
    wait_cycles(1);

    // Store word, ack on third BUSY cycle.
    do_access(1'b1, 1'b0, 32'h10, 32'h11223344, 4'b1111, 3, 32'h55555555);
    idle_inputs();
    wait_cycles(1);

    // Load, ack in first BUSY cycle.
    do_access(1'b0, 1'b1, 32'h2C, 32'h0, 4'b0000, 1, 32'hCAFEF00D);
    idle_inputs();
    wait_cycles(1);

    // Stray ack while idle must be ignored.
    stray = 1'b1;
    wait_cycles(3);
    chk("stray_stall", 32'(Stall),      32'd0);
    chk("stray_req",   32'(bus.BusReq), 32'd0);
    chk("rd_held",     RD,              32'hCAFEF00D);

    // Load that never gets an ack.
    do_access(1'b0, 1'b1, 32'h100, 32'h0, 4'b0000, 0, 32'h0);
    idle_inputs();
    wait_cycles(1);

    // Store and load together: store wins, RD untouched.
    do_access(1'b1, 1'b1, 32'h24, 32'h00AB0000, 4'b0100, 2, 32'h77777777);
    idle_inputs();
    wait_cycles(1);

    // Ack in exactly the timeout cycle: ack wins.
    do_access(1'b0, 1'b1, 32'h3C, 32'h0, 4'b0000, TIMEOUT, 32'h0BADCAFE);

    // Back-to-back: next load presented during DONE.
    do_access(1'b0, 1'b1, 32'h48, 32'h0, 4'b0000, 2, 32'h13572468);
    chk("done_no_req", 32'(bus.BusReq), 32'd0);
    idle_inputs();
    wait_cycles(1);

    // Randomized accesses.
    for (int i = 0; i < 40 && !abort; i++) begin
      case ($urandom_range(0, 2))
        0:       begin we = 1'b1; re = 1'b0; end
        1:       begin we = 1'b0; re = 1'b1; end
        default: begin we = 1'b1; re = 1'b1; end
      endcase
      if ($urandom_range(0, 5) == 0)      delay = 0;
      else if ($urandom_range(0, 3) != 0) delay = $urandom_range(1, 4);
      else                                delay = $urandom_range(1, TIMEOUT);
      a = $urandom;
      do_access(we, re, a, $urandom, 4'($urandom), delay, $urandom);
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) begin
        idle_inputs();
        wait_cycles($urandom_range(1, 3));
      end
    end
    idle_inputs();
    wait_cycles(4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_bus_bridge.md
Name: dm_bus_bridge

Overview:
- Memory-stage bridge that sits directly downstream of the store-data formatter. It also sits upstream of the load-data extender.
- Accepts the formatted write word, byte enables and write strobe, plus the load strobe and address.
- Runs each access as a req/ack transaction on a multi-cycle data-memory bus, and stalls the pipeline until the transaction completes.
- Returns the raw 32-bit read word (un-extended) to the load path. Aborts hung transactions after a timeout.

Parameters:
- TIMEOUT, 16, number of BUSY cycles without BusAck before the access is aborted (must be >= 2).
- ERR_DATA, 32'hDEADBEEF, value loaded into RD when a read times out.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- Addr  in  32  byte address from ALU; only [31:2] used.
- WD  in  32  formatted store word (already lane-aligned).
- BE  in  4  byte enables for the store.
- DMWe  in  1  store request.
- MemRead  in  1  load request.
- Stall  out  1  freeze PC and pipeline registers up to MEM.
- RD  out  32  raw read word, registered.
- BusErr  out  1  one-cycle pulse on timeout.
- BusReq  out  1  transaction request to memory.
- BusWe  out  1  1 = write transaction.
- BusAddr  out  30  word address.
- BusBE  out  4  byte enables (4'b1111 for reads).
- BusWD  out  32  write data.
- BusAck  in  1  transaction complete; BusRD valid in the same cycle.
- BusRD  in  32  read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; BusReq=0, BusWe=0, BusAddr=0, BusBE=0, BusWD=0, RD=0, BusErr=0, counter=0.
  - Reset mid-transaction drops BusReq immediately; the in-flight access is abandoned.
- Access present: acc = DMWe | MemRead. If both are asserted, the access is a write; the read is ignored and RD is unchanged.
- Stall = (state==IDLE & acc) | (state==BUSY). Stall is combinational. It is 0 in DONE.
- The CPU holds Addr/WD/BE/DMWe/MemRead stable while Stall=1. The bridge captures them anyway.
- FSM:
  - IDLE:
    - If acc, latch BusAddr=Addr[31:2] and BusWe=DMWe.
    - Latch BusBE=DMWe?BE:4'b1111 and BusWD=DMWe?WD:0.
    - Set BusReq=1, clear counter, go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - BusReq=1 and bus outputs stable.
    - On BusAck: if read, RD<=BusRD. Then BusReq<=0 and go to DONE.
    - Else if counter==TIMEOUT-1: BusErr pulses 1 for one cycle. If read, RD<=ERR_DATA. Then BusReq<=0 and go to DONE.
    - Else counter++.
  - DONE: Stall=0 for exactly one cycle so the instruction leaves MEM; go to IDLE unconditionally. An access present during DONE is not started until the following IDLE cycle.
- Latency:
  - BusAck in the first BUSY cycle gives Stall high for 2 cycles (IDLE, BUSY), then DONE.
  - Minimum access = 3 cycles.
  - RD is valid from the DONE cycle and held until the next read completes.
- BusAck outside BUSY is ignored.
- BusAck coincident with the timeout cycle: ack wins and BusErr stays 0.
- BusErr is 0 in all cycles except the timeout cycle+1 pulse (registered).
- Write transactions never modify RD.
- Counter width: $clog2(TIMEOUT). No wrap is possible because the counter clears on entry to BUSY.

Decomposition:
- Shared package dm_bus_pkg:
  - state encoding IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - BE_ALL=4'b1111.
  - default ERR_DATA.
- One sub-module: dm_timeout_cnt.
  - Parameter TIMEOUT; inputs clk, reset, clr, en; output expired.
- FSM and latches stay in dm_bus_bridge.

Test Plan:
1. Reset held low mid-BUSY with BusReq=1 -> BusReq=0 and Stall=0 the same cycle. After release: state IDLE, RD=0.
2. Store sw: Addr=0x10, WD=0x11223344, BE=4'b1111, DMWe=1; BusAck on 3rd BUSY cycle.
   - Bus sees BusAddr=0x4, BusWe=1, BusWD=0x11223344.
   - Stall high for 4 cycles, then low 1 cycle (DONE).
   - RD unchanged.
3. Load: Addr=0x2C, MemRead=1; BusAck in first BUSY cycle with BusRD=0xCAFEF00D.
   - BusBE=4'b1111, BusAddr=0xB.
   - Stall=1 for 2 cycles.
   - RD=0xCAFEF00D in DONE, held afterwards.
4. Load with no BusAck, TIMEOUT=16 -> BusErr=1 for exactly one cycle after the 16th BUSY cycle, RD=0xDEADBEEF, then DONE then IDLE.
5. DMWe=1 and MemRead=1 together, BE=4'b0100, WD=0x00AB0000 -> BusWe=1, BusBE=4'b0100, and RD keeps its previous value after ack.
6. Back-to-back: a new load is presented in the DONE cycle -> no BusReq during DONE; transaction starts from the next IDLE cycle. Stray BusAck pulse during IDLE is ignored (no state change).
